tile_ram_arbiter: RTL and testbench

TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

---
 rtl/tile_ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_tile_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_ram_arbiter.sv
`timescale 1ns/1ps
// Tile RAM arbiter: video has fixed top priority, game logic and board init share
// round-robin, game logic may lock the bus; commands are registered toward a 1-cycle sync RAM.
module tile_ram_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  input  logic          gm_req,
  input  logic          gm_we,
  input  logic [AW-1:0] gm_addr,
  input  logic [DW-1:0] gm_wdata,
  input  logic          gm_lock,
  output logic          gm_gnt,
  output logic          gm_rvalid,
  input  logic          in_req,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_wdata,
  output logic          in_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic [7:0]    conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          init_last_r, init_last_s;
  logic          vid_gnt_s, gm_gnt_s, in_gnt_s, conflict_s;
  logic          cmd_we_s;
  logic [AW-1:0] cmd_addr_s;
  logic [DW-1:0] cmd_wdata_s;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_wdata_r;
  logic          ram_we_r;
  logic          vid_rd_r, gm_rd_r;
  logic          vid_rvalid_r, gm_rvalid_r;
  logic [7:0]    conflict_cnt_r;
  logic          unused_rdata_s;

  // Read data goes straight from the RAM to the requesters; only rvalid timing is owned here.
  assign unused_rdata_s = ^ram_rdata;

  // Arbitration and next-state: grants are combinational so a withdrawn request is never granted.
  always_comb begin
    state_s     = state_r;
    init_last_s = init_last_r;
    vid_gnt_s   = 1'b0;
    gm_gnt_s    = 1'b0;
    in_gnt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        state_s = OPEN;
      end
      OPEN: begin
        if (vid_req) begin
          vid_gnt_s = 1'b1;
        end else if (gm_req && (!in_req || init_last_r)) begin
          gm_gnt_s = 1'b1;
        end else if (in_req) begin
          in_gnt_s = 1'b1;
        end else begin
          in_gnt_s = 1'b0;
        end
        if (gm_gnt_s && gm_lock) begin
          state_s = LOCKED;
        end else begin
          state_s = OPEN;
        end
      end
      LOCKED: begin
        if (vid_req) begin
          vid_gnt_s = 1'b1;
        end else if (gm_req) begin
          gm_gnt_s = 1'b1;
        end else begin
          gm_gnt_s = 1'b0;
        end
        if (gm_lock) begin
          state_s = LOCKED;
        end else begin
          state_s = OPEN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (gm_gnt_s) begin
      init_last_s = 1'b0;
    end else if (in_gnt_s) begin
      init_last_s = 1'b1;
    end else begin
      init_last_s = init_last_r;
    end
    conflict_s = (vid_req & ~vid_gnt_s) | (gm_req & ~gm_gnt_s) | (in_req & ~in_gnt_s);
  end

  // Command mux: address and data hold unless a grant loads new values.
  always_comb begin
    cmd_we_s    = 1'b0;
    cmd_addr_s  = ram_addr_r;
    cmd_wdata_s = ram_wdata_r;
    if (vid_gnt_s) begin
      cmd_addr_s = vid_addr;
    end else if (gm_gnt_s) begin
      cmd_addr_s = gm_addr;
      cmd_we_s   = gm_we;
      if (gm_we) begin
        cmd_wdata_s = gm_wdata;
      end else begin
        cmd_wdata_s = ram_wdata_r;
      end
    end else if (in_gnt_s) begin
      cmd_addr_s  = in_addr;
      cmd_we_s    = 1'b1;
      cmd_wdata_s = in_wdata;
    end else begin
      cmd_addr_s = ram_addr_r;
    end
  end

  // State, round-robin pointer and RAM command registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      init_last_r <= 1'b1;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_we_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      init_last_r <= init_last_s;
      ram_addr_r  <= cmd_addr_s;
      ram_wdata_r <= cmd_wdata_s;
      ram_we_r    <= cmd_we_s;
    end
  end

  // Two-stage read pipeline; reset flushes any read still in flight.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vid_rd_r     <= 1'b0;
      gm_rd_r      <= 1'b0;
      vid_rvalid_r <= 1'b0;
      gm_rvalid_r  <= 1'b0;
    end else begin
      vid_rd_r     <= vid_gnt_s;
      gm_rd_r      <= gm_gnt_s & ~gm_we;
      vid_rvalid_r <= vid_rd_r;
      gm_rvalid_r  <= gm_rd_r;
    end
  end

  // Saturating count of cycles in which some request lost.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      conflict_cnt_r <= 8'd0;
    end else if (conflict_s && (conflict_cnt_r != 8'hFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 8'd1;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign vid_gnt      = vid_gnt_s;
  assign gm_gnt       = gm_gnt_s;
  assign in_gnt       = in_gnt_s;
  assign vid_rvalid   = vid_rvalid_r;
  assign gm_rvalid    = gm_rvalid_r;
  assign ram_addr     = ram_addr_r;
  assign ram_wdata    = ram_wdata_r;
  assign ram_we       = ram_we_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
`timescale 1ns/1ps
// Bench for tile_ram_arbiter: a priority/round-robin/lock reference model predicts grants and
// pushes RAM commands and reads into queues; a monitor pops and compares them as the DUT presents them.
module tb_tile_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [1:0] W_NONE = 2'd0, W_VID = 2'd1, W_GM = 2'd2, W_IN = 2'd3;

  logic          CLOCK_50 = 1'b0;
  logic          resetn = 1'b0;
  logic          vid_req = 1'b0, gm_req = 1'b0, gm_we = 1'b0, gm_lock = 1'b0, in_req = 1'b0;
  logic [AW-1:0] vid_addr = '0, gm_addr = '0, in_addr = '0;
  logic [DW-1:0] gm_wdata = '0, in_wdata = '0;
  logic          vid_gnt, vid_rvalid, gm_gnt, gm_rvalid, in_gnt, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [7:0]    conflict_cnt;

  tile_ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata), .gm_lock(gm_lock),
    .gm_gnt(gm_gnt), .gm_rvalid(gm_rvalid),
    .in_req(in_req), .in_addr(in_addr), .in_wdata(in_wdata), .in_gnt(in_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [1:0]    who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } item_t;

  item_t         cmd_q[$];
  item_t         rd_q[$];
  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] ref_mem [0:15];
  int            n_chk = 0, n_err = 0, cyc = 0;
  bit            vg_seen = 0, gg_seen = 0, ig_seen = 0;
  bit            auto_drop = 1, rand_mode = 0;
  int            m_cnt = 0;
  bit            m_started = 0, m_locked = 0, m_init_last = 1;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  bit            wdata_known = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tile RAM with one cycle of read latency.
  always @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      if (i == 5) v = 8'h3C;
      mem[i] <= v;
      ref_mem[i] = v;
    end
  end

  // Reference model: decides the winner from the arbitration rules and queues expectations.
  always @(negedge CLOCK_50) begin
    logic [1:0] w;
    item_t      it;
    vg_seen = vid_gnt; gg_seen = gm_gnt; ig_seen = in_gnt;
    if (!resetn) begin
      check("rst_gnt", {29'd0, vid_gnt, gm_gnt, in_gnt}, 32'd0);
      check("rst_rvalid", {30'd0, vid_rvalid, gm_rvalid}, 32'd0);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check("rst_ram_addr", {28'd0, ram_addr}, 32'd0);
      check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      check("rst_conflict_cnt", {24'd0, conflict_cnt}, 32'd0);
      m_cnt = 0; m_started = 0; m_locked = 0; m_init_last = 1;
      rd_q.delete(); cmd_q.delete();
    end else begin
      w = W_NONE;
      if (m_started) begin
        if (vid_req) w = W_VID;
        else if (gm_req && (m_locked || !in_req || m_init_last)) w = W_GM;
        else if (in_req && !m_locked) w = W_IN;
      end
      check("grant", {29'd0, vid_gnt, gm_gnt, in_gnt}, {29'd0, w == W_VID, w == W_GM, w == W_IN});
      check("conflict_cnt", {24'd0, conflict_cnt}, m_cnt);
      if ((vid_req && w != W_VID) || (gm_req && w != W_GM) || (in_req && w != W_IN))
        if (m_cnt < 255) m_cnt++;
      it.who = w; it.due = cyc + 1;
      if (w == W_VID) begin
        it.we = 0; it.addr = vid_addr; it.data = '0;
      end else if (w == W_GM) begin
        it.we = gm_we; it.addr = gm_addr; it.data = gm_wdata;
      end else begin
        it.we = 1; it.addr = in_addr; it.data = in_wdata;
      end
      if (w != W_NONE) cmd_q.push_back(it);
      if (w != W_NONE && !it.we) begin
        it.data = ref_mem[it.addr]; it.due = cyc + 2;
        rd_q.push_back(it);
      end
      if (w == W_GM) m_init_last = 0;
      else if (w == W_IN) m_init_last = 1;
      if (m_locked) m_locked = gm_lock;
      else m_locked = (w == W_GM) && gm_lock;
      m_started = 1;
    end
  end

  // Monitor: pops RAM commands when due and reads when an rvalid appears.
  initial forever begin
    item_t e;
    @(posedge CLOCK_50); #2;
    if (!resetn) begin
      exp_addr = '0; exp_wdata = '0; wdata_known = 1;
    end else begin
      if (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
        e = cmd_q.pop_front();
        check("cmd_missed", 32'd0, 32'd1);
      end
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        e = cmd_q.pop_front();
        check("ram_we", {31'd0, ram_we}, {31'd0, e.we});
        check("ram_addr", {28'd0, ram_addr}, {28'd0, e.addr});
        exp_addr = e.addr;
        if (e.we) begin
          check("ram_wdata", {24'd0, ram_wdata}, {24'd0, e.data});
          exp_wdata = e.data; wdata_known = 1;
          ref_mem[e.addr] = e.data;
        end else if (e.who == W_GM) wdata_known = 0;
      end else begin
        check("idle_ram_we", {31'd0, ram_we}, 32'd0);
        check("hold_ram_addr", {28'd0, ram_addr}, {28'd0, exp_addr});
        if (wdata_known) check("hold_ram_wdata", {24'd0, ram_wdata}, {24'd0, exp_wdata});
      end
      if (vid_rvalid || gm_rvalid) begin
        if (rd_q.size() == 0) check("spurious_rvalid", {30'd0, vid_rvalid, gm_rvalid}, 32'd0);
        else begin
          e = rd_q.pop_front();
          check("rvalid_owner", {30'd0, vid_rvalid, gm_rvalid}, (e.who == W_VID) ? 32'd2 : 32'd1);
          check("rvalid_cycle", cyc, e.due);
          check("rdata", {24'd0, ram_rdata}, {24'd0, e.data});
        end
      end
      if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        e = rd_q.pop_front();
        check("rvalid_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50); #1;
    if (auto_drop) begin
      if (vg_seen) vid_req = 0;
      if (gg_seen) gm_req = 0;
      if (ig_seen) in_req = 0;
    end
    if (rand_mode) begin
      if (!vid_req && $urandom_range(0, 7) == 0) begin vid_req = 1; vid_addr = AW'($urandom); end
      if (!gm_req && $urandom_range(0, 2) == 0) begin
        gm_req = 1; gm_we = 1'($urandom); gm_addr = AW'($urandom); gm_wdata = DW'($urandom);
      end else if (gm_req && $urandom_range(0, 19) == 0) gm_req = 0;
      if ($urandom_range(0, 9) == 0) gm_lock = ~gm_lock;
      if (!in_req && $urandom_range(0, 2) == 0) begin
        in_req = 1; in_addr = AW'($urandom); in_wdata = DW'($urandom);
      end else if (in_req && $urandom_range(0, 19) == 0) in_req = 0;
    end
  endtask

  task automatic wait_gnt(input int who, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = (who == 0) ? vg_seen : (who == 1) ? gg_seen : ig_seen;
    end
    check("wait_gnt_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic do_reset();
    vid_req = 0; gm_req = 0; in_req = 0; gm_lock = 0;
    resetn = 0;
    step(); step();
    resetn = 1;
    step(); step();
  endtask

  initial begin
    do_reset();
    // Video read of word 5
    vid_req = 1; vid_addr = 4'd5;
    step();
    check("vid_gnt", {31'd0, vg_seen}, 32'd1);
    check("vid_cmd_addr", {28'd0, ram_addr}, 32'd5);
    check("vid_cmd_we", {31'd0, ram_we}, 32'd0);
    step();
    check("vid_rvalid", {31'd0, vid_rvalid}, 32'd1);
    check("vid_rdata", {24'd0, ram_rdata}, 32'h3C);
    step();

    // gm/init tie
    do_reset();
    gm_req = 1; gm_we = 1; gm_addr = 4'd2; gm_wdata = 8'hA1;
    in_req = 1; in_addr = 4'd7; in_wdata = 8'h0F;
    step();
    check("tie_first_gm", {30'd0, gg_seen, ig_seen}, 32'd2);
    step();
    check("tie_second_in", {30'd0, gg_seen, ig_seen}, 32'd1);
    step(); step(); step();
    check("tie_conflict_cnt", {24'd0, conflict_cnt}, 32'd1);
    check("tie_ram2", {24'd0, mem[2]}, 32'hA1);
    check("tie_ram7", {24'd0, mem[7]}, 32'h0F);

    // Three-way collision
    do_reset();
    vid_req = 1; vid_addr = 4'd6;
    gm_req = 1; gm_we = 0; gm_addr = 4'd2;
    in_req = 1; in_addr = 4'd8; in_wdata = 8'h99;
    step(); check("3way_vid", {29'd0, vg_seen, gg_seen, ig_seen}, 32'd4);
    step(); check("3way_gm", {29'd0, vg_seen, gg_seen, ig_seen}, 32'd2);
    step(); check("3way_in", {29'd0, vg_seen, gg_seen, ig_seen}, 32'd1);
    step(); step();
    check("3way_conflict_cnt", {24'd0, conflict_cnt}, 32'd2);

    // Lock sequence
    do_reset();
    gm_req = 1; gm_we = 0; gm_addr = 4'd3; gm_lock = 1;
    wait_gnt(1, 10);
    in_req = 1; in_addr = 4'd9; in_wdata = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step(); check("lock_no_in_gnt", {31'd0, ig_seen}, 32'd0);
    end
    vid_req = 1; vid_addr = 4'd1;
    step(); check("lock_vid_preempts", {31'd0, vg_seen}, 32'd1);
    gm_req = 1; gm_we = 1; gm_addr = 4'd3; gm_wdata = 8'h55; gm_lock = 0;
    step(); check("unlock_gm_write", {30'd0, gg_seen, ig_seen}, 32'd2);
    step(); check("unlock_in_gnt", {31'd0, ig_seen}, 32'd1);
    step(); step();

    // Reset in the middle of a read
    do_reset();
    gm_req = 1; gm_we = 0; gm_addr = 4'd4;
    wait_gnt(1, 10);
    resetn = 0;
    step(); check("midrst_gm_rvalid", {31'd0, gm_rvalid}, 32'd0);
    step(); check("midrst_gm_rvalid2", {31'd0, gm_rvalid}, 32'd0);
    gm_req = 1; gm_we = 0; gm_addr = 4'd4;
    resetn = 1;
    step(); check("idle_no_gnt", {31'd0, gg_seen}, 32'd0);
    step(); check("first_gnt_after_idle", {31'd0, gg_seen}, 32'd1);
    step(); step(); step();

    // Saturation
    do_reset();
    auto_drop = 0;
    vid_req = 1; vid_addr = 4'd0; in_req = 1; in_addr = 4'd1; in_wdata = 8'h11;
    repeat (300) step();
    check("sat_conflict_cnt", {24'd0, conflict_cnt}, 32'd255);
    vid_req = 0; in_req = 0; auto_drop = 1;
    step(); step(); step();

    // Randomized traffic
    do_reset();
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    vid_req = 0; gm_req = 0; in_req = 0; gm_lock = 0;
    repeat (5) step();
    check("rd_q_drained", rd_q.size(), 32'd0);
    check("cmd_q_drained", cmd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
